// File: rtl/spi_master_pkg.sv
// Shared types and default widths for the SPI master transmit path.
package spi_master_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;
    localparam int DIV_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_master_clkgen.sv
// SCLK generator: divider counter and SCLK register, with one-cycle strobes
// flagging the rise or fall that takes effect on the next clk_i edge.
module spi_master_clkgen #(
    parameter int DIV_WIDTH = spi_master_pkg::DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    output logic                 sclk_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 sclk_q;
    logic                 tick;

    assign tick   = en_i && (div_cnt == clk_div_i);
    assign rise_o = tick && !sclk_q;
    assign fall_o = tick && sclk_q;
    assign sclk_o = sclk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (clr_i) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (en_i) begin
            if (tick) begin
                div_cnt <= '0;
                sclk_q  <= ~sclk_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit engine: pulls words from the TX FIFO and shifts them
// out MSB-first for a programmable number of bits.
module spi_master_tx #(
    parameter int DATA_WIDTH = spi_master_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = spi_master_pkg::CNT_WIDTH,
    parameter int DIV_WIDTH  = spi_master_pkg::DIV_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [CNT_WIDTH-1:0]  counter_in_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  sclk_o,
    output logic                  sdo_o,
    output logic                  busy_o,
    output logic                  done_o
);

    import spi_master_pkg::*;

    localparam int WB_W = $clog2(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  bits_sent;
    logic [CNT_WIDTH-1:0]  bits_next;
    logic [WB_W-1:0]       word_bits;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  sdo_q;
    logic                  latch_cnt, load_word, shift_bit;
    logic                  clkgen_en, sclk_fall, sclk_rise_unused;

    assign bits_next = bits_sent + 1'b1;
    assign clkgen_en = (state_q == SHIFT);

    spi_master_clkgen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_clkgen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_i || !clkgen_en),
        .en_i     (clkgen_en),
        .clk_div_i(clk_div_i),
        .sclk_o   (sclk_o),
        .rise_o   (sclk_rise_unused),
        .fall_o   (sclk_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clr_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        latch_cnt = 1'b0;
        load_word = 1'b0;
        shift_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    latch_cnt = 1'b1;
                    state_d   = (counter_in_i == '0) ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    load_word = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Data only moves on the falling edge; the slave samples on the rise.
                if (sclk_fall) begin
                    shift_bit = 1'b1;
                    if (bits_next == count_q) begin
                        state_d = DONE;
                    end else if (word_bits == WB_W'(DATA_WIDTH - 1)) begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            bits_sent <= '0;
            word_bits <= '0;
            shift_reg <= '0;
            sdo_q     <= 1'b0;
        end else if (clr_i) begin
            count_q   <= '0;
            bits_sent <= '0;
            word_bits <= '0;
            shift_reg <= '0;
            sdo_q     <= 1'b0;
        end else begin
            if (latch_cnt) begin
                count_q   <= counter_in_i;
                bits_sent <= '0;
            end
            if (load_word) begin
                shift_reg <= data_i;
                word_bits <= '0;
                sdo_q     <= data_i[DATA_WIDTH-1];
            end
            if (shift_bit) begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                bits_sent <= bits_next;
                word_bits <= word_bits + 1'b1;
                // Between words sdo keeps the bit just sent; it drops to 0 at the end.
                if (state_d == SHIFT) begin
                    sdo_q <= shift_reg[DATA_WIDTH-2];
                end else if (state_d == DONE) begin
                    sdo_q <= 1'b0;
                end
            end
        end
    end

    assign sdo_o  = sdo_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: table of transfers replayed against a FIFO model
// and a bit scoreboard, plus clear/reset-in-flight sequences.
module tb_spi_master_tx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] counter_in_i = '0;
    logic [7:0]  clk_div_i = '0;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o, sclk_o, sdo_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    typedef struct {
        string       name;
        int          cnt;
        int          div;
        logic [31:0] w0;
        logic [31:0] w1;
        int          stall;
        int          en_busy_at;
        int          exp_rises;
        int          exp_pops;
        int          exp_done_k;
        int          exp_done_rel;
        int          exp_hi;
    } vec_t;

    vec_t vecs[7];

    spi_master_tx dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .en_i        (en_i),
        .counter_in_i(counter_in_i),
        .clk_div_i   (clk_div_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .sclk_o      (sclk_o),
        .sdo_o       (sdo_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k = 0, rises = 0, pops = 0, dones = 0, done_k = 0;
        int hs1 = 0, hs_last = 0, first_rdy = 0, rdy_sclk = 0;
        int hi = 0, hi_len = -1, after = 0, stall_left = 0, nwords, widx = 0, n;
        logic prev_sclk = 1'b0;
        logic hs_pend = 1'b0;
        logic [31:0] w;
        exp_q.delete();
        nwords = (v.cnt + 31) / 32;
        @(negedge clk_i);
        clk_div_i    = 8'(v.div);
        counter_in_i = 16'(v.cnt);
        data_i       = v.w0;
        valid_i      = (nwords > 0);
        en_i         = 1'b1;
        while (k < 2000 && !(dones > 0 && after >= 3)) begin
            @(negedge clk_i);
            k++;
            en_i = 1'b0;
            if (v.en_busy_at != 0 && k == v.en_busy_at) begin
                en_i         = 1'b1;
                counter_in_i = 16'd3;
            end
            if (hs_pend) begin
                valid_i    = 1'b0;
                hs_pend    = 1'b0;
                stall_left = v.stall;
            end
            if (ready_o && first_rdy == 0) first_rdy = k;
            if (ready_o && sclk_o) rdy_sclk++;
            if (sclk_o && !prev_sclk) begin
                rises++;
                if (exp_q.size() > 0) check({v.name, " sdo_bit"}, sdo_o, exp_q.pop_front());
            end
            if (sclk_o) hi++;
            else begin
                if (prev_sclk && hi_len < 0) hi_len = hi;
                hi = 0;
            end
            prev_sclk = sclk_o;
            if (done_o) begin
                dones++;
                if (done_k == 0) done_k = k;
            end
            if (dones > 0) after++;
            if (ready_o && !valid_i && widx < nwords) begin
                if (stall_left == 0) begin
                    valid_i = 1'b1;
                    data_i  = (widx == 0) ? v.w0 : v.w1;
                end else begin
                    stall_left--;
                end
            end
            if (ready_o && valid_i) begin
                pops++;
                if (pops == 1) hs1 = k;
                hs_last = k;
                w = (widx == 0) ? v.w0 : v.w1;
                n = v.cnt - 32 * widx;
                if (n > 32) n = 32;
                for (int i = 0; i < n; i++) exp_q.push_back(w[31-i]);
                widx++;
                hs_pend = 1'b1;
            end
        end
        en_i    = 1'b0;
        valid_i = 1'b0;
        check({v.name, " rises"}, rises, v.exp_rises);
        check({v.name, " pops"}, pops, v.exp_pops);
        check({v.name, " done_pulses"}, dones, 1);
        check({v.name, " bits_left"}, exp_q.size(), 0);
        check({v.name, " sclk_while_ready"}, rdy_sclk, 0);
        check({v.name, " first_ready_k"}, first_rdy, (v.cnt > 0) ? 1 : 0);
        if (v.exp_done_k >= 0) check({v.name, " done_k"}, done_k, v.exp_done_k);
        if (v.exp_done_rel >= 0) check({v.name, " done_after_hs"}, done_k - hs_last, v.exp_done_rel);
        if (v.exp_hi >= 0) check({v.name, " sclk_high_len"}, hi_len, v.exp_hi);
        if (pops == 2) check({v.name, " word_gap"}, hs_last - hs1, 2 * (v.div + 1) * 32 + 1 + v.stall);
        check({v.name, " idle_sdo"}, sdo_o, 0);
        check({v.name, " idle_busy"}, busy_o, 0);
    endtask

    // Start a 32-bit all-ones transfer at div 0 and return once nfall falls are seen.
    task automatic run_to_falls(input int nfall);
        int falls = 0, k = 0;
        logic prev_sclk = 1'b0;
        @(negedge clk_i);
        clk_div_i    = 8'd0;
        counter_in_i = 16'd32;
        data_i       = 32'hFFFF_FFFF;
        valid_i      = 1'b1;
        en_i         = 1'b1;
        while (falls < nfall && k < 200) begin
            @(negedge clk_i);
            k++;
            en_i = 1'b0;
            if (!ready_o && busy_o) valid_i = 1'b0;
            if (prev_sclk && !sclk_o) falls++;
            prev_sclk = sclk_o;
        end
        check("inflight_falls", falls, nfall);
        check("inflight_busy", busy_o, 1);
        check("inflight_sdo", sdo_o, 1);
    endtask

    initial begin
        //        name              cnt div w0            w1            stl enb rise pop dk  rel  hi
        vecs[0] = '{"one_word_div0", 8,  0, 32'hA500_0000, 32'h0,        0, 0,  8,  1, -1, 17, 1};
        vecs[1] = '{"two_word_stall",40, 1, 32'hFFFF_FFFF, 32'h0000_0000,5, 0,  40, 2, -1, 33, 2};
        vecs[2] = '{"zero_count",    0,  0, 32'h0,         32'h0,        0, 0,  0,  0,  1, -1, -1};
        vecs[3] = '{"div3",          4,  3, 32'h9000_0000, 32'h0,        0, 0,  4,  1, -1, 33, 4};
        vecs[4] = '{"en_while_busy", 8,  1, 32'h3C00_0000, 32'h0,        0, 6,  8,  1, -1, 33, 2};
        vecs[5] = '{"bits33",        33, 0, 32'h8000_0001, 32'hC000_0000,2, 0,  33, 2, -1, 3,  1};
        vecs[6] = '{"partial5",      5,  2, 32'hDEAD_BEEF, 32'h0,        0, 0,  5,  1, -1, 31, 3};

        rst_ni = 1'b0;
        #3;
        check("reset_outputs", {sclk_o, sdo_o, ready_o, busy_o, done_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        run_to_falls(10);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        check("clr_sclk", sclk_o, 0);
        check("clr_sdo", sdo_o, 0);
        check("clr_busy", busy_o, 0);
        check("clr_ready", ready_o, 0);
        run_vec(vecs[0]);

        run_to_falls(10);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_outputs", {sclk_o, sdo_o, ready_o, busy_o, done_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_vec(vecs[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
Transmit shift engine for the SPI master. It consumes 32-bit words from the TX FIFO through a valid/ready handshake and serializes them MSB-first on sdo_o in SPI mode 0 (CPOL=0, CPHA=0), with a programmable bit count and an internal SCLK divider. It sits directly downstream of the TX FIFO and is started by the SPI controller.

Parameters:
DATA_WIDTH, 32, word width taken from the FIFO
CNT_WIDTH, 16, width of the bit-count field
DIV_WIDTH, 8, width of the clock-divider field

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous reset, active low
clr_i  input  1  synchronous clear; aborts any transfer
en_i  input  1  start pulse; sampled only in IDLE
counter_in_i  input  CNT_WIDTH  total bits to send, latched on start
clk_div_i  input  DIV_WIDTH  SCLK half-period minus 1, in clk_i cycles
data_i  input  DATA_WIDTH  word from the FIFO
valid_i  input  1  FIFO word valid
ready_o  output  1  engine accepts a word
sclk_o  output  1  SPI clock
sdo_o  output  1  serial data out
busy_o  output  1  transfer in progress (state is not IDLE)
done_o  output  1  one-cycle pulse at the end of a transfer

Behaviour:
- Reset, asynchronous: state IDLE. sclk_o, sdo_o, ready_o, busy_o and done_o are all 0. Shift register, bit counter and divider counter are all 0.
- clr_i, synchronous: same values as reset on the next edge. clr_i has priority over every other input.
- State IDLE:
  - en_i=1 latches counter_in_i.
  - If the latched count is 0, go to DONE. Otherwise go to WAIT_DATA.
  - en_i is ignored in every other state.
- State WAIT_DATA:
  - ready_o=1 and sclk_o is held at 0.
  - On valid_i && ready_o: load the shift register with data_i, clear the divider, go to SHIFT.
  - Latency: en_i in cycle n gives ready_o=1 in cycle n+1.
- State SHIFT:
  - ready_o=0 and sdo_o = shift_reg[DATA_WIDTH-1].
  - The divider counts 0..clk_div_i. At the terminal count it wraps to 0 and toggles sclk_o.
  - Rising SCLK edge: no internal action; this is when the slave samples.
  - Falling SCLK edge: shift the register left by 1 and increment the bit counter.
  - After a falling edge with bits_sent == count: go to DONE.
  - Otherwise, after a falling edge with the word's 32 bits exhausted: go to WAIT_DATA. SCLK is held low (stall) until the next valid_i.
- State DONE:
  - done_o=1 for exactly one cycle and sdo_o=0, then go to IDLE.
- Timing:
  - One bit takes 2*(clk_div_i+1) cycles.
  - The handshake in cycle m gives the first SCLK rise at cycle m+1+(clk_div_i+1).
  - done_o comes 1 cycle after the last falling edge.
- Partial last word: the bits are taken from the MSB end; the unused LSBs are discarded.
- Words consumed per transfer: ceil(count/32). No word is popped beyond that.
- Bit counter: CNT_WIDTH wide. A count of 2^CNT_WIDTH-1 is legal.
- clk_div_i must stay stable while busy_o=1. A change during a transfer is undefined.
- sdo_o is 0 in IDLE and WAIT_DATA before the first load. Between words it holds the last-shifted value.

Decomposition:
- Package spi_master_pkg: state enumeration (IDLE, WAIT_DATA, SHIFT, DONE) and the default widths DATA_WIDTH, CNT_WIDTH and DIV_WIDTH.
- Sub-module spi_master_clkgen: divider counter plus sclk register. It has enable and clear inputs and outputs sclk_o and one-cycle rise_o/fall_o strobes.
- The FSM, shift register and bit counter stay in spi_master_tx.

Test Plan:
- Single word, minimum divider: clk_div_i=0, count=8, data 0xA5000000 valid from the start. Expect 8 SCLK pulses with a period of 2 cycles and sdo sequence 1,0,1,0,0,1,0,1 at the rises. done_o occurs 17 cycles after the handshake. ready_o is high for exactly one handshake.
- Multi-word with stall: count=40, clk_div_i=1, words 0xFFFFFFFF then 0x00000000 presented 5 cycles late. Expect ready_o to reassert after the 32nd fall and sclk_o to stay 0 for those 5 cycles. Expect 8 zero bits after the resume, then done_o, and exactly 2 pops.
- Zero count: en_i with counter_in_i=0. Expect done_o in cycle n+1, ready_o never high, and sclk_o always 0.
- Divider: clk_div_i=3, count=4. Expect sclk high for 4 cycles and low for 4 cycles, with a total of 32 cycles from the handshake to the last fall.
- clr_i and reset mid-transfer: assert clr_i after bit 10 of 32. Expect IDLE on the next edge with sclk_o, sdo_o and busy_o at 0. A new en_i must then work normally. Repeat with rst_ni low, where the outputs must clear asynchronously.
- en_i while busy: pulse en_i during SHIFT with a new count. Expect it to be ignored, with the original count completed and exactly one done_o.
